flash_line_buffer: RTL and testbench

CPU-side front end for the SPI flash read path. It sits between the 6809 bus (after the address decoder) and the SPI flash read engine. The block holds one line of `LINE_BYTES` consecutive flash bytes, so sequential opcode fetches are served from the buffer without an SPI transaction. On a miss it stalls the CPU with `o_MemoryReady`, requests a sequential burst from the SPI engine, fills the line, then returns the requested byte.

---
 rtl/flash_line_buffer.sv | 140 ++++++++++++++
 tb/tb_flash_line_buffer.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/flash_line_buffer.sv
// One-line read buffer between the 6809 bus and the SPI flash read engine.
// Sequential fetches hit the line; a miss stalls the CPU and refills the line by burst.
module flash_line_buffer #(
    parameter int unsigned LINE_BYTES = 8,
    parameter int unsigned ADDR_BITS  = 12,
    parameter logic [23:0] FLASH_BASE = 24'h000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_cs,
    input  logic        i_RW,
    input  logic [15:0] i_ADDRESS_BUS,
    input  logic        i_flush,
    output logic [7:0]  o_DATA,
    output logic        o_MemoryReady,
    output logic        o_burst_req,
    output logic [23:0] o_burst_addr,
    input  logic        i_byte_valid,
    input  logic [7:0]  i_byte_data,
    output logic        o_wr_ignored
);

    localparam int unsigned OFF_W = $clog2(LINE_BYTES);
    localparam int unsigned TAG_W = 24 - OFF_W;

    typedef enum logic [1:0] {ST_IDLE, ST_FILL, ST_DONE} state_e;

    state_e             state_q;
    logic [7:0]         line_q [LINE_BYTES];
    logic               valid_q;
    logic               flush_pend_q;
    logic               cs_q;
    logic               rw_q;
    logic [15:0]        addr_q;
    logic [TAG_W-1:0]   tag_q;
    logic [OFF_W-1:0]   off_q;
    logic [OFF_W-1:0]   cnt_q;
    logic [7:0]         data_q;
    logic               ready_q;
    logic               req_q;
    logic [23:0]        burst_addr_q;
    logic               wr_ign_q;

    logic [23:0]        faddr;
    logic               new_access;
    logic               hit;
    logic               last_byte;

    assign faddr      = FLASH_BASE + 24'(i_ADDRESS_BUS[ADDR_BITS-1:0]);
    assign new_access = i_cs && (!cs_q || (i_ADDRESS_BUS != addr_q) || (i_RW != rw_q));
    assign hit        = valid_q && (faddr[23:OFF_W] == tag_q);
    assign last_byte  = (cnt_q == OFF_W'(LINE_BYTES - 1));

    // Line storage is pure data; validity is tracked separately, so it needs no reset.
    always_ff @(posedge clk) begin
        if (reset && (state_q == ST_FILL) && i_byte_valid) begin
            line_q[cnt_q] <= i_byte_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            valid_q      <= 1'b0;
            flush_pend_q <= 1'b0;
            cs_q         <= 1'b0;
            rw_q         <= 1'b0;
            addr_q       <= 16'h0000;
            tag_q        <= '0;
            off_q        <= '0;
            cnt_q        <= '0;
            data_q       <= 8'h00;
            ready_q      <= 1'b1;
            req_q        <= 1'b0;
            burst_addr_q <= 24'h000000;
            wr_ign_q     <= 1'b0;
        end else begin
            wr_ign_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    cs_q         <= i_cs;
                    flush_pend_q <= 1'b0;
                    if (i_flush) begin
                        valid_q <= 1'b0;
                    end
                    if (new_access) begin
                        addr_q <= i_ADDRESS_BUS;
                        rw_q   <= i_RW;
                        if (!i_RW) begin
                            wr_ign_q <= 1'b1;
                        end else if (hit) begin
                            data_q <= line_q[faddr[OFF_W-1:0]];
                        end else begin
                            valid_q      <= 1'b0;
                            tag_q        <= faddr[23:OFF_W];
                            off_q        <= faddr[OFF_W-1:0];
                            cnt_q        <= '0;
                            burst_addr_q <= {faddr[23:OFF_W], OFF_W'(0)};
                            req_q        <= 1'b1;
                            ready_q      <= 1'b0;
                            state_q      <= ST_FILL;
                        end
                    end
                end
                ST_FILL: begin
                    if (i_flush) begin
                        flush_pend_q <= 1'b1;
                    end
                    if (i_byte_valid) begin
                        cnt_q <= cnt_q + OFF_W'(1);
                        if (last_byte) begin
                            req_q   <= 1'b0;
                            valid_q <= !(flush_pend_q || i_flush);
                            state_q <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    if (i_flush) begin
                        valid_q <= 1'b0;
                    end
                    data_q       <= line_q[off_q];
                    ready_q      <= 1'b1;
                    flush_pend_q <= 1'b0;
                    state_q      <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_DATA        = data_q;
    assign o_MemoryReady = ready_q;
    assign o_burst_req   = req_q;
    assign o_burst_addr  = burst_addr_q;
    assign o_wr_ignored  = wr_ign_q;

endmodule

// File: tb/tb_flash_line_buffer.sv
// Randomized bench for flash_line_buffer against a flat flash-image line-cache model.
module tb_flash_line_buffer;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_cs;
    logic        i_RW;
    logic [15:0] i_ADDRESS_BUS;
    logic        i_flush;
    logic [7:0]  o_DATA;
    logic        o_MemoryReady;
    logic        o_burst_req;
    logic [23:0] o_burst_addr;
    logic        i_byte_valid;
    logic [7:0]  i_byte_data;
    logic        o_wr_ignored;

    flash_line_buffer #(
        .LINE_BYTES (8),
        .ADDR_BITS  (12),
        .FLASH_BASE (24'h000000)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .i_cs          (i_cs),
        .i_RW          (i_RW),
        .i_ADDRESS_BUS (i_ADDRESS_BUS),
        .i_flush       (i_flush),
        .o_DATA        (o_DATA),
        .o_MemoryReady (o_MemoryReady),
        .o_burst_req   (o_burst_req),
        .o_burst_addr  (o_burst_addr),
        .i_byte_valid  (i_byte_valid),
        .i_byte_data   (i_byte_data),
        .o_wr_ignored  (o_wr_ignored)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: flash image plus one remembered line.
    logic [7:0]  image [4096];
    bit          mvalid;
    int          mtag;
    logic [7:0]  mdata;
    bit          prev_cs;
    logic [15:0] lat_addr;
    bit          lat_rw;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic bit is_new(input logic [15:0] addr, input bit rw);
        return !prev_cs || (addr != lat_addr) || (rw != lat_rw);
    endfunction

    task automatic model_reset();
        mvalid   = 1'b0;
        mtag     = 0;
        mdata    = 8'h00;
        prev_cs  = 1'b0;
        lat_addr = 16'h0000;
        lat_rw   = 1'b0;
    endtask

    task automatic idle_quiet(input string tag);
        chk({tag, "_rdy"}, 32'(o_MemoryReady), 32'd1);
        chk({tag, "_req"}, 32'(o_burst_req), 32'd0);
        chk({tag, "_data"}, 32'(o_DATA), 32'(mdata));
    endtask

    task automatic idle_gap();
        i_cs = 1'b0;
        tick();
        prev_cs = 1'b0;
        idle_quiet("gap");
    endtask

    task automatic flush_idle();
        i_cs    = 1'b0;
        i_flush = 1'b1;
        tick();
        i_flush = 1'b0;
        prev_cs = 1'b0;
        mvalid  = 1'b0;
        idle_quiet("flush");
    endtask

    task automatic stray_byte();
        i_cs         = 1'b0;
        i_byte_valid = 1'b1;
        i_byte_data  = 8'($urandom);
        tick();
        i_byte_valid = 1'b0;
        prev_cs      = 1'b0;
        idle_quiet("stray");
    endtask

    // fl: 0 none, 1 flush on access cycle, 2 flush mid-fill, 3 flush in DONE
    task automatic do_read(input logic [15:0] addr, input int fl);
        int fa;
        int base;
        bit nw;
        bit hit;
        fa   = int'(addr[11:0]);
        base = fa & ~7;
        nw   = is_new(addr, 1'b1);
        hit  = mvalid && (mtag == base);
        i_cs = 1'b1;
        i_RW = 1'b1;
        i_ADDRESS_BUS = addr;
        i_flush = (fl == 1);
        tick();
        i_flush = 1'b0;
        prev_cs = 1'b1;
        if (!nw || hit) begin
            if (nw) begin
                lat_addr = addr;
                lat_rw   = 1'b1;
                mdata    = image[fa];
            end
            if (fl == 1) mvalid = 1'b0;
            idle_quiet(nw ? "hit" : "same");
            return;
        end
        lat_addr = addr;
        lat_rw   = 1'b1;
        chk("miss_rdy", 32'(o_MemoryReady), 32'd0);
        chk("miss_req", 32'(o_burst_req), 32'd1);
        chk("miss_baddr", 32'(o_burst_addr), 32'(base));
        for (int k = 0; k < 8; k++) begin
            int gaps;
            gaps = int'($urandom_range(0, 2));
            for (int g = 0; g < gaps; g++) begin
                i_byte_valid = 1'b0;
                tick();
                chk("fill_rdy", 32'(o_MemoryReady), 32'd0);
                chk("fill_req", 32'(o_burst_req), 32'd1);
            end
            i_byte_valid = 1'b1;
            i_byte_data  = image[base + k];
            i_flush      = (fl == 2) && (k == 3);
            tick();
            i_byte_valid = 1'b0;
            i_flush      = 1'b0;
            chk("fill_rdy", 32'(o_MemoryReady), 32'd0);
            chk("fill_req", 32'(o_burst_req), (k < 7) ? 32'd1 : 32'd0);
        end
        i_flush = (fl == 3);
        tick();
        i_flush = 1'b0;
        mvalid = !((fl == 2) || (fl == 3));
        mtag   = base;
        mdata  = image[fa];
        chk("done_rdy", 32'(o_MemoryReady), 32'd1);
        chk("done_req", 32'(o_burst_req), 32'd0);
        chk("done_data", 32'(o_DATA), 32'(mdata));
    endtask

    task automatic do_write(input logic [15:0] addr);
        bit nw;
        nw   = is_new(addr, 1'b0);
        i_cs = 1'b1;
        i_RW = 1'b0;
        i_ADDRESS_BUS = addr;
        tick();
        prev_cs = 1'b1;
        if (nw) begin
            lat_addr = addr;
            lat_rw   = 1'b0;
        end
        chk("wr_pulse", 32'(o_wr_ignored), 32'(nw));
        idle_quiet("wr");
        tick();
        chk("wr_pulse_end", 32'(o_wr_ignored), 32'd0);
        idle_quiet("wr2");
    endtask

    task automatic reset_mid_fill(input logic [15:0] addr);
        int base;
        base = int'(addr[11:0]) & ~7;
        flush_idle();
        i_cs = 1'b1;
        i_RW = 1'b1;
        i_ADDRESS_BUS = addr;
        tick();
        chk("rst_miss_req", 32'(o_burst_req), 32'd1);
        for (int k = 0; k < 3; k++) begin
            i_byte_valid = 1'b1;
            i_byte_data  = image[base + k];
            tick();
        end
        i_byte_valid = 1'b0;
        i_cs  = 1'b0;
        reset = 1'b0;
        tick();
        chk("rst_req", 32'(o_burst_req), 32'd0);
        chk("rst_rdy", 32'(o_MemoryReady), 32'd1);
        chk("rst_data", 32'(o_DATA), 32'd0);
        chk("rst_baddr", 32'(o_burst_addr), 32'd0);
        reset = 1'b1;
        model_reset();
        do_read(addr, 0);
    endtask

    function automatic logic [15:0] rand_addr();
        if ($urandom_range(0, 9) < 8) return 16'hF000 | 16'($urandom_range(0, 47));
        return 16'($urandom);
    endfunction

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 4096; i++) image[i] = 8'($urandom);
        for (int i = 0; i < 8; i++) image[i] = 8'(8'h10 + i);
        model_reset();
        reset = 1'b0;
        i_cs = 1'b0;
        i_RW = 1'b1;
        i_ADDRESS_BUS = 16'h0000;
        i_flush = 1'b0;
        i_byte_valid = 1'b0;
        i_byte_data = 8'h00;
        @(negedge clk);
        tick();
        tick();
        chk("reset_data", 32'(o_DATA), 32'd0);
        chk("reset_rdy", 32'(o_MemoryReady), 32'd1);
        chk("reset_req", 32'(o_burst_req), 32'd0);
        chk("reset_baddr", 32'(o_burst_addr), 32'd0);
        chk("reset_wr", 32'(o_wr_ignored), 32'd0);
        reset = 1'b1;
        tick();

        do_read(16'hF005, 0);
        chk("cold_data", 32'(o_DATA), 32'h15);
        do_read(16'hF006, 0);
        chk("seq_hit0", 32'(o_DATA), 32'h16);
        do_read(16'hF007, 0);
        chk("seq_hit1", 32'(o_DATA), 32'h17);
        do_read(16'hF008, 0);
        flush_idle();
        do_read(16'hF006, 0);
        do_read(16'hF00A, 2);
        idle_gap();
        do_read(16'hF00A, 0);
        do_write(16'hF003);
        repeat (3) stray_byte();
        reset_mid_fill(16'hF020);

        for (int n = 0; n < 300; n++) begin
            int op;
            int fsel;
            op = int'($urandom_range(0, 99));
            fsel = int'($urandom_range(0, 9));
            if (op < 60) do_read(rand_addr(), (fsel < 3) ? fsel + 1 : 0);
            else if (op < 70) do_write(rand_addr());
            else if (op < 82) idle_gap();
            else if (op < 90) stray_byte();
            else if (op < 97) flush_idle();
            else reset_mid_fill(rand_addr());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
